// File: rtl/johnson_phase_seq.sv
// johnson_phase_seq
//   Parametrised Johnson-counter phase sequencer: STAGES twisted-ring flops
//   walk through P = 2*STAGES phases, decoded to a one-hot phase strobe.
//   Illegal ring states are cleared to phase 0 in one cycle and flagged.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   en         : advance one phase per cycle
//   dir        : 0 = forward (+1), 1 = reverse (-1)
//   load       : synchronous phase load strobe (wins over en)
//   load_phase : target phase index for load
//   ring       : raw Johnson state register
//   phase_idx  : decoded phase index 0..P-1 (0 for an illegal ring)
//   phase      : one-hot decoded phase, active-low when ACTIVE_LOW=1
//   wrap       : one-cycle pulse on P-1 -> 0 (fwd) or 0 -> P-1 (rev)
//   err        : one-cycle pulse on illegal ring or out-of-range load
module johnson_phase_seq #(
  parameter int unsigned STAGES     = 2,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned IW         = $clog2(2*STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [IW-1:0]         load_phase,
  output logic [STAGES-1:0]     ring,
  output logic [IW-1:0]         phase_idx,
  output logic [2*STAGES-1:0]   phase,
  output logic                  wrap,
  output logic                  err
);

  localparam int unsigned P = 2*STAGES;

  // Johnson encoding of phase k: fill ones from the bottom for k <= N,
  // then clear from the bottom for k > N.
  function automatic logic [STAGES-1:0] encode(input int unsigned k);
    logic [STAGES-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (k <= STAGES) e[i] = (i < k);
      else             e[i] = (i >= k - STAGES);
    end
    return e;
  endfunction

  logic                legal;
  logic [P-1:0]        onehot;
  logic [STAGES-1:0]   ring_nxt;
  logic                wrap_nxt;
  logic                err_nxt;

  // Decode compares the ring against every legal encoding; no match means
  // an illegal state, which leaves onehot empty (all phases inactive).
  always_comb begin
    legal     = 1'b0;
    phase_idx = '0;
    onehot    = '0;
    for (int unsigned k = 0; k < P; k++) begin
      if (ring == encode(k)) begin
        legal     = 1'b1;
        phase_idx = IW'(k);
        onehot[k] = 1'b1;
      end
    end
    phase = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_comb begin
    ring_nxt = ring;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (!legal) begin
      ring_nxt = '0;
      err_nxt  = 1'b1;
    end else if (load) begin
      if (32'(load_phase) < P) ring_nxt = encode(32'(load_phase));
      else                     err_nxt  = 1'b1;
    end else if (en) begin
      if (!dir) begin
        ring_nxt = {ring[STAGES-2:0], ~ring[STAGES-1]};
        wrap_nxt = (phase_idx == IW'(P-1));
      end else begin
        ring_nxt = {~ring[0], ring[STAGES-1:1]};
        wrap_nxt = (phase_idx == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      ring <= ring_nxt;
      wrap <= wrap_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_johnson_phase_seq.sv
module tb_johnson_phase_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: STAGES=3, active-low
  logic       rst, en, dir, load;
  logic [2:0] load_phase;
  logic [2:0] ring_a, idx_a;
  logic [5:0] phase_a;
  logic       wrap_a, err_a;

  // DUT B: STAGES=2, active-high
  logic       rst_b, en_b, dir_b, load_b;
  logic [1:0] load_phase_b;
  logic [1:0] ring_b, idx_b;
  logic [3:0] phase_b;
  logic       wrap_b, err_b;

  johnson_phase_seq #(.STAGES(3), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_phase(load_phase), .ring(ring_a), .phase_idx(idx_a),
    .phase(phase_a), .wrap(wrap_a), .err(err_a)
  );

  johnson_phase_seq #(.STAGES(2), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .dir(dir_b), .load(load_b),
    .load_phase(load_phase_b), .ring(ring_b), .phase_idx(idx_b),
    .phase(phase_b), .wrap(wrap_b), .err(err_b)
  );

  typedef struct {
    logic [2:0] ring;
    logic [2:0] idx;
    logic [5:0] phase;
    logic       wrap;
    logic       err;
    bit         skip;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m     = 0;   // reference model: current phase index of DUT A

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Johnson ring value for phase k of an n-flop ring, from the encoding rule
  function automatic logic [31:0] enc(input int n, input int k);
    int full;
    full = (1 << n) - 1;
    if (k <= n) return 32'((1 << k) - 1);
    return 32'(full & ~((1 << (k - n)) - 1));
  endfunction

  // One stimulus cycle for DUT A; the model predicts the post-edge outputs
  task automatic cyc(input logic r, input logic e, input logic d,
                     input logic l, input logic [2:0] lp);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; dir = d; load = l; load_phase = lp;
    x.skip = 1'b0; x.wrap = 1'b0; x.err = 1'b0;
    if (r) m = 0;
    else if (l) begin
      if (int'(lp) < 6) m = int'(lp);
      else              x.err = 1'b1;
    end else if (e) begin
      if (!d) begin x.wrap = (m == 5); m = (m + 1) % 6; end
      else    begin x.wrap = (m == 0); m = (m + 5) % 6; end
    end
    x.ring  = 3'(enc(3, m));
    x.idx   = 3'(m);
    x.phase = ~(6'(1) << m);
    q.push_back(x);
  endtask

  // Monitor: one expectation per clock edge while the queue has entries
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        if (!x.skip) begin
          check("ring",      32'(ring_a),  32'(x.ring));
          check("phase_idx", 32'(idx_a),   32'(x.idx));
          check("phase",     32'(phase_a), 32'(x.phase));
          check("wrap",      32'(wrap_a),  32'(x.wrap));
          check("err",       32'(err_a),   32'(x.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t x;
    int   k;
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_phase = '0;
    rst_b = 1'b1; en_b = 1'b0; dir_b = 1'b0; load_b = 1'b0; load_phase_b = '0;

    // reset held two cycles
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // forward sweep of 7 steps, wrap on 5 -> 0
    repeat (7) cyc(0, 1, 0, 0, 0);
    // load phase 0 with en high, then reverse twice, then flip back
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // load wins over en; bad load; reload of current phase
    cyc(0, 1, 0, 1, 4);
    cyc(0, 0, 0, 1, 7);
    cyc(0, 1, 1, 1, 6);
    cyc(0, 0, 0, 1, 4);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // reset with load and en high, then resume in reverse
    cyc(1, 1, 0, 1, 3);
    cyc(0, 1, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      cyc(logic'($urandom_range(0, 39) == 0),
          logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 5) == 0),
          3'($urandom_range(0, 7)));
    end

    // illegal state 010 held across one edge
    @(negedge clk);
    rst = 1'b0; en = 1'b0; load = 1'b0;
    force dut_a.ring = 3'b010;
    x.skip = 1'b0; x.ring = 3'b010; x.idx = 3'd0; x.phase = 6'h3f;
    x.wrap = 1'b0; x.err = 1'b1;
    q.push_back(x);
    #1;
    check("illegal_phase", 32'(phase_a), 32'h3f);
    check("illegal_idx",   32'(idx_a),   32'h0);
    @(negedge clk);
    release dut_a.ring;
    x.skip = 1'b1;
    q.push_back(x);
    // recovered: phase 0 held, then the next step lands on phase 1
    m = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    // DUT B: 4-phase free run, active-high
    @(negedge clk);
    rst_b = 1'b1; en_b = 1'b0;
    @(posedge clk);
    #1;
    check("b_reset_phase", 32'(phase_b), 32'h1);
    check("b_reset_idx",   32'(idx_b),   32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rst_b = 1'b0; en_b = 1'b1;
      @(posedge clk);
      #1;
      k = i % 4;
      check("b_ring",  32'(ring_b),  enc(2, k));
      check("b_phase", 32'(phase_b), 32'(1) << k);
      check("b_wrap",  32'(wrap_b),  32'(k == 0));
      check("b_err",   32'(err_b),   32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/johnson_phase_seq.md
# johnson_phase_seq

Parametrised Johnson-counter phase sequencer. It generalises the fixed 2-flop twisted-ring, 4-phase decoded generator to STAGES flops and 2×STAGES phases. It adds enable, direction, synchronous phase load, wrap and error flags, and illegal-state self-correction. It drives one-hot phase strobes, active-low by default to match the existing NAND-decoded outputs, to stepper-style or multiplexed-display logic in the user design.

## Interface
Parameters:
- STAGES, 2: number of ring flops N; legal 2..16; phase count P = 2N.
- ACTIVE_LOW, 1: 1 = phase outputs active-low, 0 = active-high.
- IW, $clog2(2*STAGES): phase index width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance one phase per cycle when high.
- dir  in  1  0 = forward (index +1), 1 = reverse (index −1).
- load  in  1  synchronous phase load strobe.
- load_phase  in  IW  target phase index for load.
- ring  out  N  raw Johnson state register.
- phase_idx  out  IW  current phase index 0..P−1, decoded from ring.
- phase  out  P  one-hot decoded phase, polarity per ACTIVE_LOW.
- wrap  out  1  registered one-cycle pulse on wrap-around.
- err  out  1  registered one-cycle pulse on illegal state or bad load.

## Operation
Encoding of phase k into ring:
- For 0 ≤ k ≤ N: the low k bits are 1 and the rest are 0.
- For N < k < P: all bits are 1 except the low (k−N) bits, which are 0.
- Example, N=3: 000, 001, 011, 111, 110, 100.

Steps:
- Forward step: ring ← {ring[N−2:0], ~ring[N−1]}.
- Reverse step: ring ← {~ring[0], ring[N−1:1]}.

Legal states: exactly the P encodings above. For N ≥ 3 the other 2^N − 2N states are illegal.

Per-cycle priority, highest first:
1. rst: ring ← 0, wrap ← 0, err ← 0.
2. Illegal ring: ring ← 0 and err ← 1. This applies regardless of en and load.
3. load:
   - load_phase < P: ring ← encoding(load_phase) and wrap ← 0.
   - load_phase ≥ P: ring holds and err ← 1.
4. en: step once per dir.
   - wrap ← 1 on a forward step from P−1 to 0.
   - wrap ← 1 on a reverse step from 0 to P−1.
5. Otherwise ring holds.

Flags and decode:
- wrap and err are 0 in any cycle whose condition does not fire. They never stick.
- phase_idx and phase are combinational decodes of the ring register only, never of inputs.
- phase[phase_idx] is active; all other bits are inactive.
- For an illegal ring (transient, one cycle at most), phase is all inactive and phase_idx is 0.
- With ACTIVE_LOW=1, phase = ~onehot. With N=2 this reproduces the NAND-decoded 4-phase behaviour.

## Timing
Reset values, visible in the cycle after the rst edge:
- ring = 0, phase_idx = 0.
- phase = ~1 for ACTIVE_LOW=1, or 1 for ACTIVE_LOW=0.
- wrap = 0, err = 0.

Latency:
- en, dir or load sampled at edge t is reflected in ring, phase_idx and phase after edge t.
- wrap and err assert in that same post-edge cycle, for exactly one cycle.

Boundary rules:
- en held with dir toggling: each cycle steps in the dir sampled that cycle. There is no dead cycle on reversal.
- load with en: load wins and no step occurs.
- Loading the current phase: ring unchanged, no wrap.
- rst mid-sequence or with load/en high: reset wins.
- Sequencing resumes on the first edge with rst low.
- Illegal-state recovery: takes one cycle. The next en step proceeds from phase 0.
- Throughput: one phase per cycle with en held high. The period is P cycles.

## Test plan
- Reset, STAGES=3, ACTIVE_LOW=1: assert rst 2 cycles → ring=000, phase_idx=0, phase=6'b111110, wrap=0, err=0.
- Forward sweep: en=1, dir=0 for 7 cycles → ring 001, 011, 111, 110, 100, 000, 001. phase_idx goes 1..5, 0, 1. wrap pulses once, on the 5→0 edge only.
- Reverse and mid-sweep reversal:
  - From phase 0: en=1, dir=1 → phase_idx 5 with wrap=1, then 4.
  - Toggle dir=0 → phase_idx 5 on the next edge, with no wrap pulse.
- Load:
  - load=1, load_phase=4, en=1 → ring=110, phase_idx=4, no step.
  - load_phase=7 → ring holds, err pulses 1 cycle.
- Illegal state, STAGES=3: force ring=010 → after 1 edge ring=000, err=1 for 1 cycle, phase all-inactive during the illegal cycle. The next en step gives phase_idx=1.
- Parameter sweep: STAGES=2, ACTIVE_LOW=0, free-run 8 cycles → 4-phase period. phase cycles 0001, 0010, 0100, 1000. err is never asserted.
